// File: rtl/fp_adder_share_arbiter.sv
// Shares one pipelined FP adder between four CORDIC requesters: round-robin issue,
// per-requester credit limits, tag-based response routing and tag error detection.
module fp_adder_share_arbiter #(
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned MAX_OUT     = 4,
  parameter logic [3:0]  IDLE_OPCODE = 4'hF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  input  logic [15:0]  req_opcode,
  input  logic [127:0] req_z,
  output logic [31:0]  adder_a,
  output logic [31:0]  adder_b,
  output logic [3:0]   adder_opcode,
  output logic [31:0]  adder_z,
  output logic [7:0]   adder_tag,
  input  logic [31:0]  adder_sum,
  input  logic         adder_done,
  input  logic [31:0]  adder_z_out,
  input  logic [7:0]   adder_tag_out,
  output logic [3:0]   rsp_valid,
  output logic [31:0]  rsp_sum,
  output logic [31:0]  rsp_z,
  output logic         busy,
  output logic         tag_err
);

  localparam int unsigned   FW         = $clog2(LATENCY + 2);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(LATENCY + 1);
  localparam logic [5:0]    MAX_OUT_C  = 6'(MAX_OUT);

  logic [1:0]    r_rr_ptr;
  logic [5:0]    r_outstanding [4];
  logic [5:0]    r_seq_issue   [4];
  logic [5:0]    r_seq_exp     [4];
  logic [FW-1:0] r_flush;

  logic [31:0] r_adder_a;
  logic [31:0] r_adder_b;
  logic [3:0]  r_adder_opcode;
  logic [31:0] r_adder_z;
  logic [7:0]  r_adder_tag;
  logic [3:0]  r_rsp_valid;
  logic [31:0] r_rsp_sum;
  logic [31:0] r_rsp_z;
  logic        r_busy;
  logic        r_tag_err;

  logic [3:0] w_eligible;
  logic [3:0] w_grant;
  logic [1:0] w_grant_id;
  logic       w_grant_any;

  logic [1:0] w_ret_id;
  logic [5:0] w_ret_seq;
  logic       w_ret_live;
  logic       w_ret_ok;
  logic       w_ret_spurious;
  logic       w_ret_seq_bad;

  logic [5:0] w_out_nxt [4];
  logic       w_busy_nxt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_eligible[i] = req_valid[i] && (r_outstanding[i] < MAX_OUT_C) && !reset;
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grant_id  = '0;
    w_grant_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_grant_any && w_eligible[r_rr_ptr + 2'(k)]) begin
        w_grant_any = 1'b1;
        w_grant_id  = r_rr_ptr + 2'(k);
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_id] = 1'b1;
    end
  end

  // Returns are ignored entirely while the flush window is open, so a stale Done
  // left in the adder by a mid-flight reset can never alias a fresh operation.
  assign w_ret_id       = adder_tag_out[7:6];
  assign w_ret_seq      = adder_tag_out[5:0];
  assign w_ret_live     = adder_done && (r_flush == '0);
  assign w_ret_ok       = w_ret_live && (r_outstanding[w_ret_id] != '0);
  assign w_ret_spurious = w_ret_live && (r_outstanding[w_ret_id] == '0);
  assign w_ret_seq_bad  = w_ret_ok && (w_ret_seq != r_seq_exp[w_ret_id]);

  always_comb begin
    w_busy_nxt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_out_nxt[i] = r_outstanding[i];
      if (w_grant[i] && !(w_ret_ok && (w_ret_id == 2'(i)))) begin
        w_out_nxt[i] = r_outstanding[i] + 6'd1;
      end else if (!w_grant[i] && w_ret_ok && (w_ret_id == 2'(i))) begin
        w_out_nxt[i] = r_outstanding[i] - 6'd1;
      end
      w_busy_nxt = w_busy_nxt | (w_out_nxt[i] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_flush        <= FLUSH_INIT;
      r_adder_a      <= '0;
      r_adder_b      <= '0;
      r_adder_opcode <= IDLE_OPCODE;
      r_adder_z      <= '0;
      r_adder_tag    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_sum      <= '0;
      r_rsp_z        <= '0;
      r_busy         <= 1'b0;
      r_tag_err      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_outstanding[i] <= '0;
        r_seq_issue[i]   <= '0;
        r_seq_exp[i]     <= '0;
      end
    end else begin
      if (r_flush != '0) begin
        r_flush <= r_flush - FW'(1);
      end

      if (w_grant_any) begin
        r_rr_ptr                <= w_grant_id + 2'd1;
        r_adder_a               <= req_a[{w_grant_id, 5'b0} +: 32];
        r_adder_b               <= req_b[{w_grant_id, 5'b0} +: 32];
        r_adder_z               <= req_z[{w_grant_id, 5'b0} +: 32];
        r_adder_opcode          <= req_opcode[{w_grant_id, 2'b0} +: 4];
        r_adder_tag             <= {w_grant_id, r_seq_issue[w_grant_id]};
        r_seq_issue[w_grant_id] <= r_seq_issue[w_grant_id] + 6'd1;
      end else begin
        r_adder_opcode <= IDLE_OPCODE;
      end

      for (int i = 0; i < 4; i++) begin
        r_outstanding[i] <= w_out_nxt[i];
      end
      r_busy <= w_busy_nxt;

      r_rsp_valid <= w_ret_ok ? (4'b0001 << w_ret_id) : 4'b0000;
      if (w_ret_ok) begin
        r_rsp_sum           <= adder_sum;
        r_rsp_z             <= adder_z_out;
        // Resync to the received sequence so one bad tag flags once, not forever.
        r_seq_exp[w_ret_id] <= w_ret_seq + 6'd1;
      end

      if (w_ret_seq_bad || w_ret_spurious) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  assign req_ready    = w_grant;
  assign adder_a      = r_adder_a;
  assign adder_b      = r_adder_b;
  assign adder_opcode = r_adder_opcode;
  assign adder_z      = r_adder_z;
  assign adder_tag    = r_adder_tag;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_sum      = r_rsp_sum;
  assign rsp_z        = r_rsp_z;
  assign busy         = r_busy;
  assign tag_err      = r_tag_err;

endmodule

// File: tb/tb_fp_adder_share_arbiter.sv
// Bench for fp_adder_share_arbiter: a stand-in adder pipeline plus a per-requester
// scoreboard and credit/round-robin model, driven by directed and random traffic.
module tb_fp_adder_share_arbiter;

  localparam int         L    = 5;
  localparam int         MO   = 4;
  localparam logic [3:0] IDLE = 4'hF;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_opcode;
  logic [127:0] req_z;
  logic [31:0]  adder_a;
  logic [31:0]  adder_b;
  logic [3:0]   adder_opcode;
  logic [31:0]  adder_z;
  logic [7:0]   adder_tag;
  logic [31:0]  adder_sum;
  logic         adder_done;
  logic [31:0]  adder_z_out;
  logic [7:0]   adder_tag_out;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_sum;
  logic [31:0]  rsp_z;
  logic         busy;
  logic         tag_err;

  always #5 clock = ~clock;

  fp_adder_share_arbiter #(.LATENCY(L), .MAX_OUT(MO), .IDLE_OPCODE(IDLE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_z(req_z),
    .adder_a(adder_a), .adder_b(adder_b), .adder_opcode(adder_opcode),
    .adder_z(adder_z), .adder_tag(adder_tag),
    .adder_sum(adder_sum), .adder_done(adder_done),
    .adder_z_out(adder_z_out), .adder_tag_out(adder_tag_out),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_z(rsp_z),
    .busy(busy), .tag_err(tag_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          out_m [4];
  int          seq_m [4];
  int          sexp_m [4];
  int          rr_m;
  int          flush_m;
  bit          err_m;
  bit          ei_v;
  logic [31:0] ei_a, ei_b, ei_z;
  logic [3:0]  ei_op;
  logic [7:0]  ei_tag;
  logic [31:0] er_sum, er_z;
  logic [63:0] sbq [4][$];

  // stand-in adder pipeline
  bit          p_v   [L+1];
  logic [7:0]  p_tag [L+1];
  logic [31:0] p_sum [L+1];
  logic [31:0] p_z   [L+1];

  bit manual = 1'b0;
  bit fixed  = 1'b0;
  int cyc    = 0;
  int last_g = -1;
  int n_grant [4];
  int n_rsp   [4];

  task automatic step(input logic [3:0] vmask, input bit rst);
    int          g;
    int          k;
    logic [3:0]  nrv;
    logic [31:0] a, b, z;
    logic [3:0]  op;
    reset = rst;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32]     = $urandom;
      req_b[32*i +: 32]     = $urandom;
      req_z[32*i +: 32]     = $urandom;
      req_opcode[4*i +: 4]  = 4'($urandom_range(0, 14));
    end
    if (fixed) begin
      req_a[63:32]     = 32'h3F800000;
      req_b[63:32]     = 32'h40000000;
      req_opcode[7:4]  = 4'h0;
    end
    req_valid = vmask;
    if (!manual) begin
      adder_done    = p_v[L];
      adder_tag_out = p_tag[L];
      adder_sum     = p_sum[L];
      adder_z_out   = p_z[L];
    end
    #1;
    g = -1;
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        k = (rr_m + j) % 4;
        if (g < 0 && vmask[k] && out_m[k] < MO) g = k;
      end
    end
    chk("req_ready", req_ready, (g >= 0) ? 4'(1 << g) : 4'b0000);
    last_g = g;

    nrv = 4'b0000;
    if (adder_done && !rst && flush_m == 0) begin
      k = int'(adder_tag_out[7:6]);
      if (out_m[k] == 0) begin
        err_m = 1'b1;
      end else begin
        if (int'(adder_tag_out[5:0]) != sexp_m[k]) err_m = 1'b1;
        sexp_m[k] = (int'(adder_tag_out[5:0]) + 1) % 64;
        out_m[k]--;
        nrv = 4'(1 << k);
        if (sbq[k].size() > 0) {er_sum, er_z} = sbq[k].pop_front();
      end
    end

    if (g >= 0) begin
      a  = req_a[32*g +: 32];
      b  = req_b[32*g +: 32];
      z  = req_z[32*g +: 32];
      op = req_opcode[4*g +: 4];
      out_m[g]++;
      rr_m   = (g + 1) % 4;
      ei_v   = 1'b1;
      ei_a   = a;
      ei_b   = b;
      ei_z   = z;
      ei_op  = op;
      ei_tag = {2'(g), 6'(seq_m[g])};
      seq_m[g] = (seq_m[g] + 1) % 64;
      sbq[g].push_back({a + b + 32'(op), z});
      n_grant[g]++;
    end else begin
      ei_v = 1'b0;
    end

    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        out_m[i] = 0; seq_m[i] = 0; sexp_m[i] = 0;
        sbq[i].delete();
      end
      rr_m = 0; flush_m = L + 1; err_m = 1'b0;
      ei_v = 1'b0; ei_a = '0; ei_b = '0; ei_z = '0; ei_tag = '0;
      er_sum = '0; er_z = '0;
    end else if (flush_m > 0) begin
      flush_m--;
    end

    @(posedge clock);
    #1;
    cyc++;
    for (int j = L; j > 0; j--) begin
      p_v[j] = p_v[j-1]; p_tag[j] = p_tag[j-1]; p_sum[j] = p_sum[j-1]; p_z[j] = p_z[j-1];
    end
    p_v[0]   = (adder_opcode != IDLE);
    p_tag[0] = adder_tag;
    p_sum[0] = adder_a + adder_b + 32'(adder_opcode);
    p_z[0]   = adder_z;

    chk("adder_opcode", adder_opcode, ei_v ? ei_op : IDLE);
    chk("adder_tag", adder_tag, ei_tag);
    chk("adder_a", adder_a, ei_a);
    chk("adder_b", adder_b, ei_b);
    chk("adder_z", adder_z, ei_z);
    chk("rsp_valid", rsp_valid, nrv);
    chk("rsp_sum", rsp_sum, er_sum);
    chk("rsp_z", rsp_z, er_z);
    chk("busy", busy, (out_m[0] + out_m[1] + out_m[2] + out_m[3]) != 0);
    chk("tag_err", tag_err, err_m);
    for (int i = 0; i < 4; i++) if (rsp_valid[i]) n_rsp[i]++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 1'b0);
  endtask

  task automatic rst_flush();
    step(4'b0000, 1'b1);
    idle(L + 2);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) begin n_grant[i] = 0; n_rsp[i] = 0; end
  endtask

  initial begin
    int          t0;
    int          lat;
    logic [63:0] e;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_z = '0; req_opcode = '0;
    adder_done = 1'b0; adder_tag_out = '0; adder_sum = '0; adder_z_out = '0;
    for (int j = 0; j <= L; j++) begin p_v[j] = 1'b0; p_tag[j] = '0; p_sum[j] = '0; p_z[j] = '0; end
    clr_counts();

    step(4'b0000, 1'b1);
    step(4'b1111, 1'b1);
    chk("reset_opcode", adder_opcode, IDLE);
    chk("reset_busy", busy, 1'b0);
    idle(L + 2);

    // single operation from requester 1
    fixed = 1'b1; t0 = cyc;
    step(4'b0010, 1'b0);
    fixed = 1'b0;
    chk("single_tag", adder_tag, 8'h40);
    lat = -1;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      step(4'b0000, 1'b0);
      if (rsp_valid == 4'b0010) lat = cyc - t0;
    end
    chk("single_latency", lat, 7);
    chk("single_sum", rsp_sum, 32'h7F800000);
    idle(3);

    // fairness with all requesters valid
    rst_flush();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0);
      chk("fair_order", last_g, i % 4);
    end
    idle(12);

    // credit limit on requester 2
    rst_flush(); clr_counts();
    for (int i = 0; i < 14; i++) begin
      step(4'b0100, 1'b0);
      if (i == 6) chk("credit_grants", n_grant[2], 4);
    end
    idle(12);

    // sequence number wrap on requester 0
    rst_flush(); clr_counts();
    for (int i = 0; i < 400 && n_rsp[0] < 70; i++) step((n_grant[0] < 70) ? 4'b0001 : 4'b0000, 1'b0);
    chk("wrap_rsp_count", n_rsp[0], 70);
    chk("wrap_tag_err", tag_err, 1'b0);
    idle(4);

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0));
    idle(12);

    // reset with operations inside the adder
    rst_flush();
    step(4'b0111, 1'b0); step(4'b0111, 1'b0); step(4'b0111, 1'b0); step(4'b0000, 1'b0);
    chk("midflight_busy", busy, 1'b1);
    step(4'b0000, 1'b1);
    chk("midflight_busy_rst", busy, 1'b0);
    clr_counts();
    idle(L + 3);
    chk("midflight_no_rsp", n_rsp[0] + n_rsp[1] + n_rsp[2] + n_rsp[3], 0);
    chk("midflight_tag_err", tag_err, 1'b0);
    step(4'b0010, 1'b0);
    chk("midflight_new_tag", adder_tag, 8'h40);
    idle(12);

    // wrong sequence number and spurious Done, driven by hand
    rst_flush();
    repeat (4) step(4'b0001, 1'b0);
    idle(10);
    manual = 1'b1; adder_done = 1'b0;
    step(4'b0001, 1'b0);
    idle(2);
    e = (sbq[0].size() > 0) ? sbq[0][0] : 64'd0;
    adder_done = 1'b1; adder_tag_out = 8'h05; adder_sum = e[63:32]; adder_z_out = e[31:0];
    step(4'b0000, 1'b0);
    adder_done = 1'b0;
    chk("inject_rsp", rsp_valid, 4'b0001);
    chk("inject_err", tag_err, 1'b1);
    adder_done = 1'b1; adder_tag_out = 8'hC0;
    step(4'b0000, 1'b0);
    adder_done = 1'b0;
    chk("spurious_drop", rsp_valid, 4'b0000);
    idle(L + 2);
    manual = 1'b0;

    // spurious Done after the flush window raises tag_err
    rst_flush();
    manual = 1'b1;
    adder_done = 1'b1; adder_tag_out = 8'hC0;
    step(4'b0000, 1'b0);
    adder_done = 1'b0;
    chk("spurious_err", tag_err, 1'b1);
    idle(L + 2);
    manual = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
